// File: rtl/fft_iter_ctrl_if.sv
// rtl/fft_iter_ctrl_if.sv - start/status and memory-address bundle of the FFT sequencer
// FFT_CTRL_STALL_EN adds the stall input.
interface fft_iter_ctrl_if #(
  parameter int LOG2N = 10
);
  localparam int STW = $clog2(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic [STW-1:0]   stage;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_addr;
  logic             bfly_strb;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
`ifdef FFT_CTRL_STALL_EN
  logic             stall;

  modport master (
    input  start, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bfly_strb, wr_en, wr_addr_a, wr_addr_b
  );
  modport slave (
    output start, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bfly_strb, wr_en, wr_addr_a, wr_addr_b
  );
`else
  modport master (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bfly_strb, wr_en, wr_addr_a, wr_addr_b
  );
  modport slave (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bfly_strb, wr_en, wr_addr_a, wr_addr_b
  );
`endif
endinterface

// File: rtl/fft_iter_ctrl.sv
// rtl/fft_iter_ctrl.sv - in-place iterative radix-2 DIT FFT address/strobe sequencer
// FFT_CTRL_STALL_EN adds a stall input that freezes issue during RUN.
module fft_iter_ctrl #(
  parameter int LOG2N    = 10,
  parameter int BFLY_LAT = 3,
  parameter int STRB_DLY = 2
) (
  input  logic            clk,
  input  logic            rst,
  fft_iter_ctrl_if.master bus
);
  localparam int STW = $clog2(LOG2N);
  localparam int JW  = LOG2N - 1;
  localparam int GW  = $clog2(BFLY_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t           state_q, state_d;
  logic [JW-1:0]    j_q, j_d;
  logic [STW-1:0]   stage_q, stage_d;
  logic [GW-1:0]    gap_q, gap_d;

  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] addr_a_q, addr_a_d;
  logic [LOG2N-1:0] addr_b_q, addr_b_d;
  logic [JW-1:0]    tw_q, tw_d;
  logic             busy_q, done_q;
  logic [STW-1:0]   stage_out_q;

  logic [BFLY_LAT-1:0] en_dly_q;
  logic [LOG2N-1:0]    a_dly_q [BFLY_LAT];
  logic [LOG2N-1:0]    b_dly_q [BFLY_LAT];

  logic             issue_ok;
  logic [LOG2N-1:0] j_ext, mask, k_ext;
  logic [JW-1:0]    k_j;
  logic [STW-1:0]   tw_shift;

`ifdef FFT_CTRL_STALL_EN
  assign issue_ok = ~bus.stall;
`else
  assign issue_ok = 1'b1;
`endif

  // Address a is j with a zero bit inserted at position 'stage'; b sets that bit.
  always_comb begin
    j_ext    = {1'b0, j_q};
    mask     = (LOG2N'(1) << stage_q) - LOG2N'(1);
    k_j      = j_q & mask[JW-1:0];
    k_ext    = {1'b0, k_j};
    tw_shift = STW'(LOG2N - 1) - stage_q;
  end

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    stage_d  = stage_q;
    gap_d    = gap_q;
    rd_en_d  = 1'b0;
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          j_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (issue_ok) begin
          rd_en_d  = 1'b1;
          addr_a_d = ((j_ext & ~mask) << 1) | k_ext;
          addr_b_d = addr_a_d | (mask + LOG2N'(1));
          tw_d     = k_j << tw_shift;
          j_d      = j_q + JW'(1);
          if (&j_q) begin
            state_d = DRAIN;
            gap_d   = '0;
          end
        end
      end
      DRAIN: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(BFLY_LAT - 1)) begin
          gap_d = '0;
          if (stage_q == STW'(LOG2N - 1)) begin
            state_d = FIN;
          end else begin
            stage_d = stage_q + STW'(1);
            state_d = RUN;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      j_q         <= '0;
      stage_q     <= '0;
      gap_q       <= '0;
      rd_en_q     <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      tw_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stage_out_q <= '0;
    end else begin
      state_q     <= state_d;
      j_q         <= j_d;
      stage_q     <= stage_d;
      gap_q       <= gap_d;
      rd_en_q     <= rd_en_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      tw_q        <= tw_d;
      busy_q      <= (state_q != IDLE);
      done_q      <= (state_q == FIN);
      stage_out_q <= stage_q;
    end
  end

  // Read addresses are already zero when rd_en is low, so the taps carry zeros too.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_dly_q <= '0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        a_dly_q[i] <= '0;
        b_dly_q[i] <= '0;
      end
    end else begin
      en_dly_q   <= {en_dly_q[BFLY_LAT-2:0], rd_en_q};
      a_dly_q[0] <= addr_a_q;
      b_dly_q[0] <= addr_b_q;
      for (int i = 1; i < BFLY_LAT; i++) begin
        a_dly_q[i] <= a_dly_q[i-1];
        b_dly_q[i] <= b_dly_q[i-1];
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_out_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = addr_a_q;
  assign bus.rd_addr_b = addr_b_q;
  assign bus.tw_addr   = tw_q;
  assign bus.bfly_strb = en_dly_q[STRB_DLY-1];
  assign bus.wr_en     = en_dly_q[BFLY_LAT-1];
  assign bus.wr_addr_a = a_dly_q[BFLY_LAT-1];
  assign bus.wr_addr_b = b_dly_q[BFLY_LAT-1];
endmodule

// File: tb/tb_fft_iter_ctrl.sv
// tb/tb_fft_iter_ctrl.sv - scoreboard bench for fft_iter_ctrl (LOG2N=3 and LOG2N=10 instances)
`timescale 1ns/1ps
module tb_fft_iter_ctrl;
  localparam int LOG2N    = 3;
  localparam int N        = 1 << LOG2N;
  localparam int LAT      = 3;
  localparam int SDLY     = 2;
  localparam int BIG      = 10;
  localparam int NOM_DONE = LOG2N * (N / 2 + LAT) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_iter_ctrl_if #(.LOG2N(LOG2N)) bus ();
  fft_iter_ctrl_if #(.LOG2N(BIG))   bbus ();

  fft_iter_ctrl #(.LOG2N(LOG2N), .BFLY_LAT(LAT), .STRB_DLY(SDLY)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fft_iter_ctrl #(.LOG2N(BIG), .BFLY_LAT(LAT), .STRB_DLY(SDLY)) dut_big (
    .clk(clk), .rst(rst), .bus(bbus)
  );

  typedef struct { int a; int b; int tw; int st; } op_t;
  op_t exp_rd[$];
  op_t exp_wr[$];
  int  h_en[16];
  int  h_a[16];
  int  h_b[16];
  int  cyc    = 0;
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_transform();
    for (int s = 0; s < LOG2N; s++) begin
      for (int j = 0; j < N / 2; j++) begin
        op_t o;
        int  h = 1 << s;
        o.a  = (j / h) * 2 * h + (j % h);
        o.b  = o.a + h;
        o.tw = (j % h) * ((N / 2) / h);
        o.st = s;
        exp_rd.push_back(o);
        exp_wr.push_back(o);
      end
    end
  endtask

  task automatic sample();
    int  i  = cyc % 16;
    int  i2 = (cyc + 14) % 16;
    int  i3 = (cyc + 13) % 16;
    op_t o;
    h_en[i] = bus.rd_en ? 1 : 0;
    h_a[i]  = 32'(bus.rd_addr_a);
    h_b[i]  = 32'(bus.rd_addr_b);
    if (bus.rd_en) begin
      if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
      else begin
        o = exp_rd.pop_front();
        chk("rd_addr_a", 32'(bus.rd_addr_a), o.a);
        chk("rd_addr_b", 32'(bus.rd_addr_b), o.b);
        chk("tw_addr", 32'(bus.tw_addr), o.tw);
        chk("stage", 32'(bus.stage), o.st);
      end
    end
    chk("bfly_strb", 32'(bus.bfly_strb), h_en[i2]);
    if (bus.wr_en) begin
      if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
      else begin
        o = exp_wr.pop_front();
        chk("wr_addr_a", 32'(bus.wr_addr_a), o.a);
        chk("wr_addr_b", 32'(bus.wr_addr_b), o.b);
      end
      chk("wr_lat_en", 1, h_en[i3]);
      chk("wr_lat_a", 32'(bus.wr_addr_a), h_a[i3]);
      chk("wr_lat_b", 32'(bus.wr_addr_b), h_b[i3]);
    end else begin
      chk("wr_lat_en", 0, h_en[i3]);
      chk("wr_idle_a", 32'(bus.wr_addr_a), 0);
      chk("wr_idle_b", 32'(bus.wr_addr_b), 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_stage"}, 32'(bus.stage), 0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, "_rd_a"}, 32'(bus.rd_addr_a), 0);
    chk({tag, "_rd_b"}, 32'(bus.rd_addr_b), 0);
    chk({tag, "_tw"}, 32'(bus.tw_addr), 0);
    chk({tag, "_strb"}, 32'(bus.bfly_strb), 0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({tag, "_wr_a"}, 32'(bus.wr_addr_a), 0);
    chk({tag, "_wr_b"}, 32'(bus.wr_addr_b), 0);
  endtask

  // Called at a negedge with the DUT idle; edge after this call is edge 0.
  task automatic run_one(input int done_exp, input int ign_a, input int ign_b,
                         input int stl_a, input int stl_b);
    push_transform();
    bus.start = 1'b1;
    step();
    for (int r = 0; r <= done_exp + 1; r++) begin
      if (r > 0) step();
      bus.start = (r + 1 == ign_a || r + 1 == ign_b);
`ifdef FFT_CTRL_STALL_EN
      bus.stall = (r + 1 == stl_a || r + 1 == stl_b);
`endif
      chk("busy", 32'(bus.busy), (r >= 1 && r <= done_exp) ? 1 : 0);
      chk("done", 32'(bus.done), (r == done_exp) ? 1 : 0);
      if (stl_a < 0)
        chk("rd_slot", 32'(bus.rd_en),
            (r >= 1 && r < done_exp && (r - 1) % (N / 2 + LAT) < N / 2) ? 1 : 0);
    end
    chk("rd_left", exp_rd.size(), 0);
    chk("wr_left", exp_wr.size(), 0);
  endtask

  task automatic run_reset();
    push_transform();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int r = 1; r <= 10; r++) step();
    chk("pre_rst_rd_en", 32'(bus.rd_en), 1);
    chk("pre_rst_stage", 32'(bus.stage), 1);
    rst = 1'b1;
    exp_rd.delete();
    exp_wr.delete();
    for (int i = 0; i < 16; i++) begin
      h_en[i] = 0;
      h_a[i]  = 0;
      h_b[i]  = 0;
    end
    step();
    rst = 1'b0;
    check_all_zero("rst");
    for (int r = 12; r <= 14; r++) begin
      step();
      chk("rst_no_wr", 32'(bus.wr_en), 0);
      chk("rst_idle_busy", 32'(bus.busy), 0);
    end
  endtask

  task automatic run_big();
    int rd_n = 0, wr_n = 0, done_at = -1, done_n = 0, tw_i = 0;
    bbus.start = 1'b1;
    @(negedge clk);
    bbus.start = 1'b0;
    for (int r = 0; r <= 5160; r++) begin
      if (r > 0) @(negedge clk);
      if (bbus.rd_en) begin
        rd_n++;
        if (bbus.stage == 9) begin
          chk("big_tw", 32'(bbus.tw_addr), tw_i);
          tw_i++;
        end
      end
      if (bbus.wr_en) wr_n++;
      if (bbus.done) begin
        done_n++;
        if (done_at < 0) done_at = r;
      end
    end
    chk("big_rd_count", rd_n, 5120);
    chk("big_wr_count", wr_n, 5120);
    chk("big_done_cycle", done_at, 5151);
    chk("big_done_count", done_n, 1);
    chk("big_tw_count", tw_i, 512);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bbus.start = 1'b0;
`ifdef FFT_CTRL_STALL_EN
    bus.stall  = 1'b0;
    bbus.stall = 1'b0;
`endif
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    run_one(NOM_DONE, 5, NOM_DONE, -1, -1);
    run_one(NOM_DONE, -1, -1, -1, -1);
    run_reset();
    run_one(NOM_DONE, -1, -1, -1, -1);
`ifdef FFT_CTRL_STALL_EN
    run_one(NOM_DONE + 2, -1, -1, 2, 3);
`endif
    run_big();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fft_iter_ctrl.md
Name: fft_iter_ctrl

Overview:
- Sequencer for the in-place, iterative radix-2 DIT FFT built around the pipelined complex butterfly.
- Generates the ping addresses (A/B read), the twiddle ROM address, the butterfly strobe and the delayed write-back addresses for all LOG2N stages of an N-point transform.
- Data memory is assumed loaded in bit-reversed order before start.
- Inserts a drain gap between stages so that no read of stage s+1 precedes the last write of stage s.

Parameters:
- LOG2N, 10, log2 of transform size N; N = 2**LOG2N, valid range 2..12.
- BFLY_LAT, 3, cycles from rd_en to the matching wr_en (memory read latency + butterfly latency); must be ≥ 2.
- STRB_DLY, 2, cycles from rd_en to bfly_strb; must satisfy 1 ≤ STRB_DLY < BFLY_LAT.
- STW (localparam), $clog2(LOG2N), width of the stage index.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset, synchronous, active-high.
- start, in, 1, one-cycle request to begin a transform; ignored unless idle.
- busy, out, 1, high from the cycle after start is accepted until done inclusive.
- done, out, 1, one-cycle pulse after the final write.
- stage, out, STW, stage index of the current read stream.
- rd_en, out, 1, read issue for addresses below.
- rd_addr_a, out, LOG2N, upper-leg address.
- rd_addr_b, out, LOG2N, lower-leg address.
- tw_addr, out, LOG2N-1, twiddle ROM index, valid with rd_en.
- bfly_strb, out, 1, strobe to butterfly strb_in.
- wr_en, out, 1, write-back enable.
- wr_addr_a, out, LOG2N, write address for dout1.
- wr_addr_b, out, LOG2N, write address for dout2.

Behaviour:
- States: IDLE, RUN, DRAIN, FIN.
- Registered outputs; reset value 0 for every output, all counters and the delay line.
- IDLE:
  - start=1 → RUN next cycle; stage=0, j=0.
  - busy rises together with the first rd_en.
- RUN:
  - One butterfly per cycle; rd_en=1; j counts 0..N/2-1.
  - Address rules, with h = 2**stage, k = j & (h-1), g = j >> stage:
    - rd_addr_a = (g << (stage+1)) | k
    - rd_addr_b = rd_addr_a + h
    - tw_addr = k << (LOG2N-1-stage)
  - When j = N/2-1 → DRAIN; j wraps to 0.
- DRAIN:
  - rd_en=0 for exactly BFLY_LAT cycles (gap counter).
  - On expiry: if stage < LOG2N-1, increment stage → RUN; else → FIN.
- FIN:
  - done=1 for one cycle; busy=1 this cycle.
  - Next cycle: IDLE, busy=0, stage=0.
- Delay line (shift registers on rd_en and both addresses):
  - bfly_strb = rd_en delayed STRB_DLY cycles.
  - wr_en, wr_addr_a, wr_addr_b = rd_en / rd_addr_a / rd_addr_b delayed BFLY_LAT cycles.
  - Address taps hold 0 when the corresponding enable is 0.
- Latency: start accepted at edge 0 → first rd_en in cycle 1; done in cycle LOG2N*(N/2+BFLY_LAT)+1.
- Boundary conditions:
  - start while busy: ignored; no restart, no effect on counters.
  - start in the same cycle as done (FIN): ignored; a new start is accepted only in IDLE.
  - rst mid-transform: next cycle IDLE, all outputs 0, delay line flushed; no stale wr_en ever appears after reset.
  - stage wrap: stage never exceeds LOG2N-1; j never exceeds N/2-1.

Optional Feature:
- Macro: FFT_CTRL_STALL_EN.
- Defined:
  - Adds input port stall (1 bit).
  - While stall=1 in RUN, rd_en=0 and j/addresses hold; the delay line keeps shifting, so in-flight butterflies still complete.
  - stall has no effect in IDLE, DRAIN or FIN.
  - The done cycle slips by the number of stalled RUN cycles.
- Undefined: no stall port; RUN issues every cycle unconditionally.

Test Plan:
- LOG2N=3, BFLY_LAT=3, STRB_DLY=2, start pulse → reads, with tw_addr 0 in stage 0:
  - stage 0 (a,b): (0,1) (2,3) (4,5) (6,7); tw_addr 0,0,0,0.
  - stage 1: (0,2) (1,3) (4,6) (5,7); tw_addr 0,2,0,2.
  - stage 2: (0,4) (1,5) (2,6) (3,7); tw_addr 0,1,2,3.
  - done in cycle 22; busy high cycles 1..22.
- Same config → each wr_en/wr_addr pair equals the rd pair exactly 3 cycles earlier; bfly_strb is rd_en shifted 2.
  - Exactly 3 idle rd cycles between stages; last stage-s write precedes first stage-s+1 read.
- start pulsed at cycles 5 and 22 (FIN) → ignored; one done only; after IDLE, a start at cycle 24 runs a full second transform identically.
- rst asserted at cycle 10 (stage 1 mid-stream) → cycle 11: all outputs 0, IDLE; no wr_en in cycles 11..14; subsequent start gives the nominal sequence.
- LOG2N=10 default, start → 5120 rd_en cycles, 5120 wr_en cycles; done at cycle 10*(512+3)+1 = 5151; final stage tw_addr = 0..511.
- FFT_CTRL_STALL_EN, LOG2N=3, stall=1 for cycles 2-3 → j holds at 1 (addr pair (2,3) reissued after stall); done at cycle 24.
